// File: rtl/mem_wb_align.sv
// MEM/WB stage: extracts and extends the addressed load sub-word, selects load or ALU
// data, and registers the writeback record along with a retired-instruction counter.
module mem_wb_align #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_stall,
    input  logic             mem_valid,
    input  logic [XLEN-1:0]  mem_pc,
    input  logic [31:0]      mem_instr,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_ld_funct,
    input  logic [2:0]       mem_addr_lo,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_pc,
    output logic [31:0]      wb_instr,
    output logic [4:0]       wb_rd,
    output logic             wb_wen,
    output logic [XLEN-1:0]  wb_wdata,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] commit_count
);

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_data;
    logic            misalign;
    logic [XLEN-1:0] wdata_next;
    logic            wen_next;

    assign raw = mem_rdata >> {mem_addr_lo, 3'b000};

    always_comb begin
        ld_data = raw;
        case (mem_ld_funct)
            3'b000:  ld_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  ld_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b010:  ld_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, raw[15:0]};
            3'b110:  ld_data = {{(XLEN-32){1'b0}}, raw[31:0]};
            default: ld_data = raw;
        endcase
    end

    // funct3[1:0] encodes the access size for both signed and unsigned loads
    always_comb begin
        misalign = 1'b0;
        if (mem_is_load) begin
            case (mem_ld_funct[1:0])
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = mem_addr_lo[0];
                2'b10:   misalign = |mem_addr_lo[1:0];
                default: misalign = |mem_addr_lo;
            endcase
        end
    end

    always_comb begin
        wdata_next = mem_alu_result;
        if (mem_is_load) begin
            wdata_next = misalign ? '0 : ld_data;
        end
        wen_next = mem_wen & (mem_rd != 5'd0) & ~misalign;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_pc        <= '0;
            wb_instr     <= '0;
            wb_rd        <= '0;
            wb_wen       <= 1'b0;
            wb_wdata     <= '0;
            wb_misalign  <= 1'b0;
            commit_count <= '0;
        end else if (flush || (!stall && (mem_stall || !mem_valid))) begin
            wb_valid    <= 1'b0;
            wb_pc       <= '0;
            wb_instr    <= '0;
            wb_rd       <= '0;
            wb_wen      <= 1'b0;
            wb_wdata    <= '0;
            wb_misalign <= 1'b0;
        end else if (!stall) begin
            // Misaligned loads still retire so the trace stays complete
            wb_valid     <= 1'b1;
            wb_pc        <= mem_pc;
            wb_instr     <= mem_instr;
            wb_rd        <= mem_rd;
            wb_wen       <= wen_next;
            wb_wdata     <= wdata_next;
            wb_misalign  <= misalign;
            commit_count <= commit_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/mem_wb_align.md
Name: mem_wb_align

Overview:
- MEM/WB pipeline stage, directly downstream of the data-memory access stage.
- Takes the raw 64-bit dbus read word and the load type, extracts and sign/zero-extends the addressed sub-word, selects load data or ALU result, and registers the writeback record.
- Drives the regfile write port, the WB forwarding path and commit info, and keeps a retired-instruction counter.

Parameters:
- XLEN, 64, data width
- CNT_W, 64, width of the commit counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- stall  in  1  global pipeline stall; hold all stage registers
- flush  in  1  load a bubble into the stage on the next edge
- mem_stall  in  1  memory stage still waiting on dbus (its stall_this_dbus)
- mem_valid  in  1  MEM-stage slot holds a real instruction
- mem_pc  in  XLEN  instruction PC
- mem_instr  in  32  instruction word
- mem_rd  in  5  destination register
- mem_wen  in  1  instruction writes rd
- mem_is_load  in  1  instruction is a load
- mem_ld_funct  in  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- mem_addr_lo  in  3  dbus address bits [2:0]
- mem_alu_result  in  XLEN  non-load result
- mem_rdata  in  XLEN  raw dbus read word, 8-byte aligned
- wb_valid  out  1  WB slot valid
- wb_pc  out  XLEN  committed PC
- wb_instr  out  32  committed instruction
- wb_rd  out  5  regfile write address
- wb_wen  out  1  regfile write enable
- wb_wdata  out  XLEN  regfile write data, also the forwarding value
- wb_misalign  out  1  misaligned load flagged in the WB slot
- commit_count  out  CNT_W  number of retired instructions

Behaviour:
- All outputs are registers. Reset (reset=1 at a posedge) clears every output to 0. Reset overrides flush and stall.
- Latency: 1 cycle, MEM inputs to WB outputs. Extraction and the load/ALU mux are combinational on the inputs; the result is registered.
- Update priority at each posedge, reset excluded:
  1. flush=1: stage becomes a bubble, even if stall=1.
  2. Else stall=1: hold all registers, including commit_count.
  3. Else mem_stall=1 or mem_valid=0: stage becomes a bubble.
  4. Else: capture the instruction.
- Bubble means wb_valid=0, wb_wen=0, wb_misalign=0. wb_pc, wb_instr, wb_rd and wb_wdata are don't-care but are set to 0.
- Extraction: sh = mem_addr_lo*8; raw = mem_rdata >> sh.
  - LB: sext(raw[7:0]); LBU: zext(raw[7:0])
  - LH: sext(raw[15:0]); LHU: zext(raw[15:0])
  - LW: sext(raw[31:0]); LWU: zext(raw[31:0])
  - LD: raw
  - funct3 111: treated as LD.
- Alignment rules:
  - LH/LHU need addr_lo[0]=0.
  - LW/LWU need addr_lo[1:0]=0.
  - LD needs addr_lo=0.
  - Violation: wb_misalign=1, wb_wen=0, wb_valid=1 (the instruction still retires for trace), wb_wdata=0.
- Non-load: wb_wdata=mem_alu_result; mem_ld_funct and mem_addr_lo are ignored; wb_misalign=0.
- wb_wen = mem_wen & (mem_rd != 0) & ~misalign for valid captures, so x0 is never written.
- commit_count increments by 1 on each edge that captures a valid instruction, misaligned ones included. It wraps modulo 2^CNT_W. No increment on bubble, stall or flush.
- Stall-then-release: registers hold their value across any number of stall cycles. A capture happens only on the first non-stalled edge, and counts exactly once.
- mem_stall=1 with stall=0: a bubble is inserted each cycle, so a multi-cycle dbus access produces exactly one valid WB entry, on the edge after mem_stall drops.

Test Plan:
- Reset: reset=1 for 2 cycles with mem_valid=1 -> all outputs 0, commit_count=0. After release, one ALU op (rd=5, result 0x1234) -> next cycle wb_wen=1, wb_rd=5, wb_wdata=0x1234, commit_count=1.
- Sub-word extraction: mem_rdata=0x8877_6655_4433_2211, then:
  - LB, addr_lo=7 -> 0xFFFF_FFFF_FFFF_FF88
  - LBU, addr_lo=7 -> 0x0000_0000_0000_0088
  - LH, addr_lo=6 -> 0xFFFF_FFFF_FFFF_8877
  - LWU, addr_lo=4 -> 0x0000_0000_8877_6655
  - LD, addr_lo=0 -> 0x8877_6655_4433_2211
- Misalign: LW with addr_lo=2 -> wb_valid=1, wb_misalign=1, wb_wen=0, commit_count increments. LH with addr_lo=1 -> same result.
- x0 suppression: valid ALU op with rd=0, mem_wen=1 -> wb_wen=0, wb_valid=1.
- Memory wait: load presented with mem_stall=1 for 3 cycles, then 0 -> 3 bubble cycles (wb_valid=0), then exactly one valid entry; commit_count +1 only.
- Stall/flush priority:
  - stall=1 for 4 cycles while the inputs change -> outputs frozen.
  - stall=1 and flush=1 together -> bubble next cycle, commit_count unchanged.
  - commit_count preset near wrap (CNT_W=4, count 15) plus one commit -> 0.
